pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the 8-bit processor. It supersedes the fixed 32-bit PC register and next-PC logic with configurable widths and a branch condition set extended by a signed less-than branch. It adds a hardware return-address stack (RAS) for call/return. It sits between the control unit (mode select), the ALU (flags) and the instruction cache (PC address), and stalls on either memory busywait.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and all address arithmetic.
- OFFSET_WIDTH, 8, width of the signed word offset from the instruction.
- RAS_DEPTH, 4, return-address stack entries (≥2, power of two).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUSYWAIT  in  1  data-memory stall.
- INSTR_CACHE_BUSYWAIT  in  1  instruction-cache stall.
- PC_MODE  in  3  next-PC mode: 000 seq, 001 jump, 010 beq, 011 bne, 100 blt, 101 call, 110 ret, 111 reserved (acts as seq).
- ZERO  in  1  ALU zero flag.
- NEG  in  1  ALU result sign bit.
- OFFSET  in  OFFSET_WIDTH  signed word offset.
- PC  out  PC_WIDTH  current instruction address.
- PC_NEXT  out  PC_WIDTH  combinational next PC.
- STALL  out  1  BUSYWAIT | INSTR_CACHE_BUSYWAIT.
- RAS_EMPTY  out  1  stack holds 0 entries.
- RAS_FULL  out  1  stack holds RAS_DEPTH entries.
- RAS_OVERFLOW  out  1  sticky: call made while full.
- RAS_UNDERFLOW  out  1  sticky: ret made while empty.

## Operation
- SEQ = PC + 4. TARGET = SEQ + (sign_extend(OFFSET) << 2). Both wrap modulo 2^PC_WIDTH; no overflow flag.
- Taken condition: jump always; beq ZERO; bne ~ZERO; blt NEG; call always; seq/reserved never.
- PC_NEXT: taken → TARGET; ret → top of RAS (SEQ if empty); otherwise SEQ.
- RAS is a circular buffer with top pointer and count (0..RAS_DEPTH).
- call: push SEQ, count += 1. If full, overwrite oldest entry, count stays RAS_DEPTH, set RAS_OVERFLOW.
- ret, non-empty: pop, count -= 1. Empty: no pop, PC_NEXT = SEQ, set RAS_UNDERFLOW.
- Sticky flags clear only on RESET.
- Stall (STALL=1 at rising edge): PC, RAS contents, pointer, count and flags hold. PC_NEXT is still computed but is not committed. A call/ret held across stall cycles pushes/pops exactly once, on the first non-stalled edge.
- Reset values: PC = RESET_VECTOR, count = 0, pointer = 0, RAS_EMPTY = 1, RAS_FULL = 0, RAS_OVERFLOW = 0, RAS_UNDERFLOW = 0. Stack entries are don't-care.

## Timing
- Single clock domain. Synchronous, active-high reset. RESET has priority over stall and all modes, including a call/ret in the same cycle.
- PC_NEXT and STALL are combinational from PC, PC_MODE, ZERO, NEG, OFFSET, RAS top and the busywaits; no registered latency.
- PC updates one edge after mode/flags are presented: at non-stalled edge n, PC ← PC_NEXT.
- RAS push/pop commits at the same edge as PC. RAS_EMPTY/RAS_FULL are valid the same cycle the count changes.
- Reset mid-stall: PC = RESET_VECTOR at that edge; stall is ignored.
- Behavioural RTL with no # delays. The upstream control unit owns its own decode latency.

## Test plan
- Reset, then 3 seq cycles with no stall → PC = 0, 4, 8, 12. Flags all 0. RAS_EMPTY = 1.
- PC = 0x10. beq with OFFSET = 0xFE: ZERO = 1 → PC = 0x0C; ZERO = 0 → PC = 0x14. bne inverts. blt with NEG = 1 → taken.
- PC = 0x100, call OFFSET = 0x10 → PC = 0x144, RAS top = 0x104. Then ret → PC = 0x104, RAS_EMPTY = 1.
- RAS_DEPTH = 4: 5 nested calls → RAS_FULL = 1, RAS_OVERFLOW = 1. 4 rets return the 4 newest return addresses. A 5th ret → PC = SEQ, RAS_UNDERFLOW = 1.
- Call with INSTR_CACHE_BUSYWAIT high for 3 edges, then low → PC and count frozen for 3 edges, then exactly one push. Repeat with BUSYWAIT.
- PC = 0xFFFFFFFC, seq → PC = 0. Assert RESET during a stalled ret with RAS_EMPTY = 0 → PC = RESET_VECTOR, count = 0, flags cleared.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle between control/ALU/cache side and the PC sequencer.
// The master drives mode, flags, offset and stalls; the slave returns PC state.
interface pc_sequencer_if #(
    parameter int PC_WIDTH     = 32,
    parameter int OFFSET_WIDTH = 8
);
    logic                    BUSYWAIT;
    logic                    INSTR_CACHE_BUSYWAIT;
    logic [2:0]              PC_MODE;
    logic                    ZERO;
    logic                    NEG;
    logic [OFFSET_WIDTH-1:0] OFFSET;
    logic [PC_WIDTH-1:0]     PC;
    logic [PC_WIDTH-1:0]     PC_NEXT;
    logic                    STALL;
    logic                    RAS_EMPTY;
    logic                    RAS_FULL;
    logic                    RAS_OVERFLOW;
    logic                    RAS_UNDERFLOW;

    modport master (
        output BUSYWAIT, INSTR_CACHE_BUSYWAIT, PC_MODE, ZERO, NEG, OFFSET,
        input  PC, PC_NEXT, STALL, RAS_EMPTY, RAS_FULL,
        input  RAS_OVERFLOW, RAS_UNDERFLOW
    );

    modport slave (
        input  BUSYWAIT, INSTR_CACHE_BUSYWAIT, PC_MODE, ZERO, NEG, OFFSET,
        output PC, PC_NEXT, STALL, RAS_EMPTY, RAS_FULL,
        output RAS_OVERFLOW, RAS_UNDERFLOW
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump and a circular
// return-address stack; all state freezes while either memory stalls.
module pc_sequencer #(
    parameter int                     PC_WIDTH     = 32,
    parameter int                     OFFSET_WIDTH = 8,
    parameter int                     RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    pc_sequencer_if.slave   bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {
        M_SEQ  = 3'b000,
        M_JUMP = 3'b001,
        M_BEQ  = 3'b010,
        M_BNE  = 3'b011,
        M_BLT  = 3'b100,
        M_CALL = 3'b101,
        M_RET  = 3'b110,
        M_RSVD = 3'b111
    } pc_mode_e;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]       ptr_q, ptr_d, ptr_inc;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [PC_WIDTH-1:0] seq_pc, tgt_pc, off_ext, ras_top;
    logic                empty, full, stall;
    logic                taken, is_ret, push, pop;
    pc_mode_e            mode;

    assign mode    = pc_mode_e'(bus.PC_MODE);
    assign stall   = bus.BUSYWAIT | bus.INSTR_CACHE_BUSYWAIT;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));
    assign ras_top = ras_q[ptr_q];
    assign ptr_inc = ptr_q + PW'(1);

    assign off_ext = {{(PC_WIDTH-OFFSET_WIDTH){bus.OFFSET[OFFSET_WIDTH-1]}},
                      bus.OFFSET};
    assign seq_pc  = pc_q + PC_WIDTH'(4);
    assign tgt_pc  = seq_pc + {off_ext[PC_WIDTH-3:0], 2'b00};

    // Decode mode into branch decision and stack operation.
    always_comb begin
        taken  = 1'b0;
        is_ret = 1'b0;
        push   = 1'b0;
        case (mode)
            M_JUMP:  taken = 1'b1;
            M_BEQ:   taken = bus.ZERO;
            M_BNE:   taken = ~bus.ZERO;
            M_BLT:   taken = bus.NEG;
            M_CALL: begin
                taken = 1'b1;
                push  = 1'b1;
            end
            M_RET:   is_ret = 1'b1;
            default: taken = 1'b0;
        endcase
        pop = is_ret & ~empty;
    end

    // Next PC and next stack bookkeeping; an empty-stack return falls through.
    always_comb begin
        pc_d  = seq_pc;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (taken) begin
            pc_d = tgt_pc;
        end else if (pop) begin
            pc_d = ras_top;
        end
        if (push) begin
            ptr_d = ptr_inc;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (pop) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
        if (is_ret && empty) begin
            unf_d = 1'b1;
        end
    end

    // Commit PC and stack control on non-stalled edges; reset dominates.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!stall) begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Push writes one slot past the top; when full this overwrites the oldest.
    always_ff @(posedge CLK) begin
        if (!RESET && !stall && push) begin
            ras_q[ptr_inc] <= seq_pc;
        end
    end

    assign bus.PC            = pc_q;
    assign bus.PC_NEXT       = pc_d;
    assign bus.STALL         = stall;
    assign bus.RAS_EMPTY     = empty;
    assign bus.RAS_FULL      = full;
    assign bus.RAS_OVERFLOW  = ovf_q;
    assign bus.RAS_UNDERFLOW = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed steps against a queue-based PC/RAS model;
// expected PCs go through a scoreboard queue and are checked after each edge.
module tb_pc_sequencer;
    logic CLK = 1'b0;
    logic RESET;

    pc_sequencer_if #(.PC_WIDTH(32), .OFFSET_WIDTH(8)) bus ();

    pc_sequencer #(
        .PC_WIDTH(32),
        .OFFSET_WIDTH(8),
        .RAS_DEPTH(4),
        .RESET_VECTOR(32'h0)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int fails   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        logic [31:0] obs, exp;
        obs = {28'h0, bus.RAS_EMPTY, bus.RAS_FULL,
               bus.RAS_OVERFLOW, bus.RAS_UNDERFLOW};
        exp = {28'h0, (m_ras.size() == 0), (m_ras.size() == 4), m_ovf, m_unf};
        check(tag, obs, exp);
    endtask

    task automatic do_reset(input logic [2:0] m, input logic bw);
        RESET              = 1'b1;
        bus.PC_MODE        = m;
        bus.BUSYWAIT       = bw;
        bus.INSTR_CACHE_BUSYWAIT = 1'b0;
        m_pc  = 32'h0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_q.push_back(m_pc);
        @(posedge CLK);
        #1;
        RESET        = 1'b0;
        bus.BUSYWAIT = 1'b0;
        bus.PC_MODE  = 3'b000;
        check("reset_pc", bus.PC, exp_q.pop_front());
        check_flags("reset_flags");
    endtask

    task automatic step(input logic [2:0] m, input logic z, input logic n,
                        input logic [7:0] o, input logic bw, input logic ibw);
        logic [31:0] seq, tgt, nxt;
        int          so;
        logic        tk;
        bus.PC_MODE  = m;
        bus.ZERO     = z;
        bus.NEG      = n;
        bus.OFFSET   = o;
        bus.BUSYWAIT = bw;
        bus.INSTR_CACHE_BUSYWAIT = ibw;
        seq = m_pc + 32'd4;
        so  = int'($signed(o));
        tgt = seq + 32'(so * 4);
        tk  = (m == 3'd1) || (m == 3'd5) || (m == 3'd2 && z) ||
              (m == 3'd3 && !z) || (m == 3'd4 && n);
        if (tk) nxt = tgt;
        else if (m == 3'd6 && m_ras.size() != 0) nxt = m_ras[$];
        else nxt = seq;
        #1;
        check("pc_next", bus.PC_NEXT, nxt);
        check("stall", {31'h0, bus.STALL}, {31'h0, bw | ibw});
        if (!(bw || ibw)) begin
            m_pc = nxt;
            if (m == 3'd5) begin
                m_ras.push_back(seq);
                if (m_ras.size() > 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end else if (m == 3'd6) begin
                if (m_ras.size() != 0) void'(m_ras.pop_back());
                else m_unf = 1'b1;
            end
        end
        exp_q.push_back(m_pc);
        @(posedge CLK);
        #1;
        check("pc", bus.PC, exp_q.pop_front());
        check_flags("flags");
    endtask

    task automatic goto(input logic [31:0] addr);
        int d;
        d = int'(addr - m_pc - 32'd4);
        step(3'd1, 1'b0, 1'b0, 8'(d / 4), 1'b0, 1'b0);
    endtask

    initial begin
        RESET        = 1'b1;
        bus.PC_MODE  = 3'b000;
        bus.ZERO     = 1'b0;
        bus.NEG      = 1'b0;
        bus.OFFSET   = 8'h00;
        bus.BUSYWAIT = 1'b0;
        bus.INSTR_CACHE_BUSYWAIT = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset(3'd0, 1'b0);

        repeat (3) step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("seq_pc12", bus.PC, 32'h0000_000C);

        goto(32'h10);
        step(3'd2, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        check("beq_taken", bus.PC, 32'h0000_000C);
        goto(32'h10);
        step(3'd2, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0);
        check("beq_not", bus.PC, 32'h0000_0014);
        goto(32'h10);
        step(3'd3, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0);
        check("bne_taken", bus.PC, 32'h0000_000C);
        goto(32'h10);
        step(3'd3, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        goto(32'h10);
        step(3'd4, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        check("blt_taken", bus.PC, 32'h0000_000C);
        step(3'd4, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0);
        step(3'd7, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0);

        goto(32'h100);
        step(3'd5, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        check("call_pc", bus.PC, 32'h0000_0144);
        step(3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ret_pc", bus.PC, 32'h0000_0104);
        check("ret_empty", {31'h0, bus.RAS_EMPTY}, 32'h1);

        for (int i = 0; i < 5; i++)
            step(3'd5, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
        check("ovf_full", {30'h0, bus.RAS_FULL, bus.RAS_OVERFLOW}, 32'h3);
        for (int i = 0; i < 5; i++)
            step(3'd6, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
        check("unf", {31'h0, bus.RAS_UNDERFLOW}, 32'h1);

        repeat (3) step(3'd5, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
        step(3'd5, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        repeat (3) step(3'd5, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
        step(3'd5, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
        repeat (2) step(3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("one_pop", {31'h0, bus.RAS_EMPTY}, 32'h0);

        do_reset(3'd6, 1'b1);

        step(3'd1, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0);
        check("to_top", bus.PC, 32'hFFFF_FFFC);
        step(3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("wrap", bus.PC, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
